// File: rtl/int2flt_sequencer.sv
// int2flt_sequencer: streams 16-bit integers through the int2flt core via its data memory and returns float16 results
module int2flt_sequencer #(
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        core_start,
  input  logic        core_done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_timeout,
  output logic [15:0] conv_count
);
  localparam int SW = $clog2(START_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] ST_LAST = SW'(START_CYCLES - 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, START, WAIT, RD_LO, RD_HI, OUT} state_t;
  state_t state_q, state_d;
  logic [15:0] data_q, data_d, res_q, res_d, cnt_q, cnt_d;
  logic to_q, to_d;
  logic [SW-1:0] st_q, st_d;
  logic [WW-1:0] wd_q, wd_d;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      data_q <= '0;
      res_q <= '0;
      cnt_q <= '0;
      to_q <= 1'b0;
      st_q <= '0;
      wd_q <= '0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
      to_q <= to_d;
      st_q <= st_d;
      wd_q <= wd_d;
    end
  end
  always_comb begin
    state_d = state_q;
    data_d = data_q;
    res_d = res_q;
    cnt_d = cnt_q;
    to_d = to_q;
    st_d = st_q;
    wd_d = wd_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = WR_LO;
        data_d = in_data;
        res_d = '0;
        to_d = 1'b0;
      end
      WR_LO: state_d = WR_HI;
      WR_HI: begin
        state_d = START;
        st_d = '0;
      end
      // done is not looked at here: it may still be high from the previous run
      START: if (st_q == ST_LAST) begin
        state_d = WAIT;
        wd_d = '0;
      end else st_d = st_q + 1'b1;
      WAIT: if (core_done) state_d = RD_LO;
      else if (wd_q == WD_LAST) begin
        state_d = OUT;
        to_d = 1'b1;
        res_d = '0;
      end else wd_d = wd_q + 1'b1;
      RD_LO: begin
        res_d[7:0] = mem_rdata;
        state_d = RD_HI;
      end
      RD_HI: begin
        res_d[15:8] = mem_rdata;
        cnt_d = cnt_q + 1'b1;
        state_d = OUT;
      end
      OUT: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign in_ready = (state_q == IDLE) && !reset;
  assign mem_we = (state_q == WR_LO) || (state_q == WR_HI);
  assign mem_addr = (state_q == WR_HI) ? 8'd1 : (state_q == RD_LO) ? 8'd2 : (state_q == RD_HI) ? 8'd3 : 8'd0;
  assign mem_wdata = (state_q == WR_LO) ? data_q[7:0] : (state_q == WR_HI) ? data_q[15:8] : 8'd0;
  assign core_start = state_q == START;
  assign out_valid = state_q == OUT;
  assign out_data = res_q;
  assign out_timeout = to_q;
  assign conv_count = cnt_q;
endmodule

// File: doc/int2flt_sequencer.md
# int2flt_sequencer

Front-end controller for the `int2flt` conversion core. It accepts 16-bit two's-complement integers over a valid/ready stream and writes each operand into the core's data memory (bytes 0/1). It then pulses the core's `start`, waits for `done`, reads the half-precision result back (bytes 3/2) and presents it on a valid/ready output stream. It also provides a watchdog timeout and a completed-conversion counter, so the core can be driven by upstream logic instead of a testbench.

## Interface
Parameters:
- `START_CYCLES`, default 2: number of cycles `core_start` is held high per conversion (≥1).
- `TIMEOUT`, default 1023: maximum cycles spent waiting for `core_done` (≥1).

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand valid.
- `in_ready`  out  1  sequencer idle, can accept an operand.
- `in_data`  in  16  integer operand.
- `mem_we`  out  1  data-memory write enable.
- `mem_addr`  out  8  data-memory byte address.
- `mem_wdata`  out  8  data-memory write byte.
- `mem_rdata`  in  8  data-memory read byte, combinational from `mem_addr`.
- `core_start`  out  1  start request to the core.
- `core_done`  in  1  core completion level.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts result.
- `out_data`  out  16  float16 result `{mem[3],mem[2]}`, or 0 on timeout.
- `out_timeout`  out  1  qualifies `out_valid`: the core never signalled done.
- `conv_count`  out  16  number of successful conversions, wraps at 0xFFFF→0.

## Operation
- FSM states: IDLE, WR_LO, WR_HI, START, WAIT, RD_LO, RD_HI, OUT.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid`, latch `in_data` and go to WR_LO.
- **WR_LO:** `mem_we`=1, `mem_addr`=0, `mem_wdata`=`in_data[7:0]`; go to WR_HI.
- **WR_HI:** `mem_we`=1, `mem_addr`=1, `mem_wdata`=`in_data[15:8]`; go to START.
- **START:**
  - `core_start`=1 for exactly `START_CYCLES` cycles.
  - `core_done` is ignored, because a stale done from the previous run may still be high.
  - Then go to WAIT with the watchdog cleared.
- **WAIT:**
  - `core_done`=1 → go to RD_LO.
  - Otherwise the watchdog increments. After `TIMEOUT` WAIT cycles with no done → go to OUT, set the timeout flag and clear the result register.
- **RD_LO:** `mem_addr`=2; capture `mem_rdata` into result[7:0]; go to RD_HI.
- **RD_HI:**
  - `mem_addr`=3; capture `mem_rdata` into result[15:8].
  - Increment `conv_count`.
  - Go to OUT.
- **OUT:**
  - `out_valid`=1; `out_data` and `out_timeout` are held stable.
  - On `out_ready` → go to IDLE.
- Outside WR_LO/WR_HI: `mem_we`=0 and `mem_wdata`=0. `mem_addr`=0 in IDLE, START, WAIT and OUT.
- `in_valid` outside IDLE is ignored, never queued.
- The watchdog counter is `$clog2(TIMEOUT+1)` bits wide. `conv_count` does not increment on a timeout.

## Timing
- **Reset values:** state IDLE; `in_ready`=0 while `reset` is high, 1 once released; every other output 0, including `conv_count`.
- **Accept:** handshake sampled at edge E0. Schedule relative to E0:
  - WR_LO in cycle 1, WR_HI in cycle 2.
  - START in cycles 3..2+`START_CYCLES`.
  - WAIT starts in cycle 3+`START_CYCLES`.
- **Minimum latency** (`START_CYCLES`=2, done already high in the first WAIT cycle): WAIT cycle 5, RD_LO 6, RD_HI 7, `out_valid` rises in cycle 8.
- **Memory timing:** writes are sampled by the memory at the end of the WR cycle. Reads are combinational, so they are captured at the end of the RD cycle.
- **Timeout timing:** WAIT cycles 5..4+`TIMEOUT`; `out_valid` with `out_timeout`=1 in cycle 5+`TIMEOUT`.
- **Result handoff:** `out_valid` falls the cycle after the `out_ready` handshake. `in_ready` rises in that same cycle.
- **Back-to-back throughput:** one conversion per 9 cycles minimum (`START_CYCLES`=2, zero-wait core, `out_ready` tied high).
- **Reset mid-operation:**
  - All outputs and state return to reset values immediately; `core_start` and `mem_we` drop asynchronously.
  - The latched operand is discarded.
  - The first conversion after release behaves normally.

## Test plan
- **Reset:** assert `reset` mid-cycle with no clock edge → all outputs 0 immediately; after release, `in_ready`=1 and `conv_count`=0.
- **Single conversion:** `in_data`=0x0001; core stub raises done 3 cycles after `core_start` falls and writes mem[3]=0x3C, mem[2]=0x00 → writes addr0=0x01 then addr1=0x00, `core_start` high exactly 2 cycles, `out_data`=0x3C00, `out_timeout`=0, `conv_count`=1.
- **Back-to-back:** `in_valid` held with 0xFFC0 then 0x7F00, zero-wait stub, `out_ready`=1 → outputs 0xD400 then 0x77F0, in order. Second accept occurs exactly 9 cycles after the first.
- **Backpressure:** `out_ready`=0 for 5 cycles in OUT → `out_valid`/`out_data` stable, `in_ready`=0, and a concurrent `in_valid`=0x1234 is not written to memory.
- **Timeout:** `TIMEOUT`=16, stub never raises done → `out_valid` in cycle 21 after accept, `out_timeout`=1, `out_data`=0x0000, `conv_count` unchanged.
- **Reset in WAIT:** `reset` pulse during WAIT → `core_start`/`out_valid` 0 and state IDLE. A following 0x0002 conversion (stub result 0x4000) completes with `out_data`=0x4000.
